alu_arbiter: RTL

Shares one combinational ArithmeticLogicUnit instance between two requesters: port 0 (main execute path) and port 1 (secondary user, e.g. address/branch-target generation). Each cycle it grants at most one valid request using round-robin priority and drives the granted operands and opcode to the shared ALU. It registers the ALU result into that port's one-entry response buffer. Responses use valid/ready handshakes, so a stalled consumer never loses a result.

---
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin arbiter grants at most one request per cycle. The ALU
// result is captured into a one-entry response buffer for the granted
// port. Each buffer is drained through a valid/ready handshake.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    // Port 0 request
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [XLEN-1:0] i_req0_rs1,
    input  logic [XLEN-1:0] i_req0_rs2,
    input  logic [XLEN-1:0] i_req0_imm,
    input  logic            i_req0_imm_sel,
    input  logic [3:0]      i_req0_op,
    input  logic [TAGW-1:0] i_req0_tag,

    // Port 1 request
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [XLEN-1:0] i_req1_rs1,
    input  logic [XLEN-1:0] i_req1_rs2,
    input  logic [XLEN-1:0] i_req1_imm,
    input  logic            i_req1_imm_sel,
    input  logic [3:0]      i_req1_op,
    input  logic [TAGW-1:0] i_req1_tag,

    // Port 0 response
    output logic            o_rsp0_valid,
    input  logic            i_rsp0_ready,
    output logic [XLEN-1:0] o_rsp0_data,
    output logic            o_rsp0_zero,
    output logic [TAGW-1:0] o_rsp0_tag,

    // Port 1 response
    output logic            o_rsp1_valid,
    input  logic            i_rsp1_ready,
    output logic [XLEN-1:0] o_rsp1_data,
    output logic            o_rsp1_zero,
    output logic [TAGW-1:0] o_rsp1_tag,

    // Shared ALU
    output logic [XLEN-1:0] o_alu_rs1,
    output logic [XLEN-1:0] o_alu_rs2,
    output logic [XLEN-1:0] o_alu_imm,
    output logic            o_alu_imm_sel,
    output logic [3:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic            i_alu_zero
);

    // Opcode driven to the ALU when nothing is granted.
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic {
        PRIO_PORT0 = 1'b0,
        PRIO_PORT1 = 1'b1
    } prio_t;

    prio_t prio;
    prio_t prio_next;

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // Decide eligibility and grants. A full buffer that is being drained
    // this cycle counts as free. No grant is issued while reset is held.
    always_comb begin
        elig0  = 1'b0;
        elig1  = 1'b0;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rst_n) begin
            elig0  = i_req0_valid && (!o_rsp0_valid || i_rsp0_ready);
            elig1  = i_req1_valid && (!o_rsp1_valid || i_rsp1_ready);
            grant0 = elig0 && (!elig1 || (prio == PRIO_PORT0));
            grant1 = elig1 && (!elig0 || (prio == PRIO_PORT1));
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    // Round-robin update: favour the other port after a grant, otherwise hold.
    always_comb begin
        prio_next = prio;
        if (grant0) begin
            prio_next = PRIO_PORT1;
        end else if (grant1) begin
            prio_next = PRIO_PORT0;
        end
    end

    // Priority register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio <= PRIO_PORT0;
        end else begin
            prio <= prio_next;
        end
    end

    // Steer the granted port's operands to the ALU, or drive idle values (add of zeros).
    always_comb begin
        o_alu_rs1     = '0;
        o_alu_rs2     = '0;
        o_alu_imm     = '0;
        o_alu_imm_sel = 1'b0;
        o_alu_op      = ALU_ADD;
        if (grant0) begin
            o_alu_rs1     = i_req0_rs1;
            o_alu_rs2     = i_req0_rs2;
            o_alu_imm     = i_req0_imm;
            o_alu_imm_sel = i_req0_imm_sel;
            o_alu_op      = i_req0_op;
        end else if (grant1) begin
            o_alu_rs1     = i_req1_rs1;
            o_alu_rs2     = i_req1_rs2;
            o_alu_imm     = i_req1_imm;
            o_alu_imm_sel = i_req1_imm_sel;
            o_alu_op      = i_req1_op;
        end
    end

    // Port 0 response buffer: a new result wins over a drain in the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp0_valid <= 1'b0;
            o_rsp0_data  <= '0;
            o_rsp0_zero  <= 1'b0;
            o_rsp0_tag   <= '0;
        end else if (grant0) begin
            o_rsp0_valid <= 1'b1;
            o_rsp0_data  <= i_alu_res;
            o_rsp0_zero  <= i_alu_zero;
            o_rsp0_tag   <= i_req0_tag;
        end else if (o_rsp0_valid && i_rsp0_ready) begin
            o_rsp0_valid <= 1'b0;
        end
    end

    // Port 1 response buffer: a new result wins over a drain in the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp1_valid <= 1'b0;
            o_rsp1_data  <= '0;
            o_rsp1_zero  <= 1'b0;
            o_rsp1_tag   <= '0;
        end else if (grant1) begin
            o_rsp1_valid <= 1'b1;
            o_rsp1_data  <= i_alu_res;
            o_rsp1_zero  <= i_alu_zero;
            o_rsp1_tag   <= i_req1_tag;
        end else if (o_rsp1_valid && i_rsp1_ready) begin
            o_rsp1_valid <= 1'b0;
        end
    end

endmodule
